// File: rtl/pipe_pkg.sv
// Shared definitions for the write-back stage: datapath defaults,
// the MEM/WB bundle and the bubble that flushes/stalls/resets load.
package pipe_pkg;

    localparam int WIDTH_DEFAULT   = 32;
    localparam int RN_BITS_DEFAULT = 5;

    // One memory-stage slot as it travels into write-back.
    typedef struct packed {
        logic                       valid;
        logic                       wreg;
        logic                       m2reg;
        logic [RN_BITS_DEFAULT-1:0] wn;
        logic [WIDTH_DEFAULT-1:0]   alu_result;
        logic [WIDTH_DEFAULT-1:0]   mem_out;
    } mem_wb_t;

    // Empty slot: not valid, no write, all payload cleared.
    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/pipe_wb_mem_wb_reg.sv
// MEM/WB pipeline register. Reset, flush and stall all load the same
// bubble, so their relative priority never changes the outcome.
module MEM_WB_reg
    import pipe_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    stall,
    input  logic    flush,
    input  mem_wb_t d,
    output mem_wb_t q
);

    mem_wb_t slot_reg;

    // Capture the memory-stage slot, or a bubble when it must be discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg <= MEM_WB_BUBBLE;
        end else if (flush) begin
            slot_reg <= MEM_WB_BUBBLE;
        end else if (stall) begin
            slot_reg <= MEM_WB_BUBBLE;
        end else begin
            slot_reg <= d;
        end
    end

    assign q = slot_reg;

endmodule

// File: rtl/pipe_wb.sv
// Write-back stage: MEM/WB register, write-back mux, 2-read/1-write
// register file with write-through bypass, and retired-instruction counter.
module pipe_wb
    import pipe_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int RN_BITS = RN_BITS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEMvalid,
    input  logic               MEMwreg,
    input  logic               MEMm2reg,
    input  logic [RN_BITS-1:0] MEMwn,
    input  logic [WIDTH-1:0]   MEMaluResult,
    input  logic [WIDTH-1:0]   MEMmemOut,
    input  logic               stall,
    input  logic               flush,
    input  logic [RN_BITS-1:0] rna,
    input  logic [RN_BITS-1:0] rnb,
    output logic [WIDTH-1:0]   qa,
    output logic [WIDTH-1:0]   qb,
    output logic               WBwreg,
    output logic [RN_BITS-1:0] WBwn,
    output logic [WIDTH-1:0]   WBdata,
    output logic [31:0]        WBretired
);

    localparam int NREGS = 1 << RN_BITS;

    mem_wb_t mem_slot;
    mem_wb_t wb_slot;

    // The bundle struct is sized by the package defaults, so WIDTH and
    // RN_BITS are expected to stay at those values.
    assign mem_slot.valid      = MEMvalid;
    assign mem_slot.wreg       = MEMwreg;
    assign mem_slot.m2reg      = MEMm2reg;
    assign mem_slot.wn         = MEMwn;
    assign mem_slot.alu_result = MEMaluResult;
    assign mem_slot.mem_out    = MEMmemOut;

    MEM_WB_reg u_mem_wb_reg (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .d     (mem_slot),
        .q     (wb_slot)
    );

    assign WBwreg = wb_slot.valid & wb_slot.wreg;
    assign WBwn   = wb_slot.wn;
    assign WBdata = wb_slot.m2reg ? wb_slot.mem_out : wb_slot.alu_result;

    // r0 is hard-wired to zero, so writes aimed at it are dropped here.
    logic rf_we;
    assign rf_we = WBwreg && (WBwn != '0);

    logic [WIDTH-1:0] regs_reg [NREGS];

    // Register file: cleared on reset, reset also blocks the WB commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (rf_we) begin
            regs_reg[WBwn] <= WBdata;
        end
    end

    // Read ports: r0 reads zero, otherwise the in-flight WB value wins
    // over the stored entry so decode sees it in the same cycle.
    logic [RN_BITS-1:0] rd_addr [2];
    logic [WIDTH-1:0]   rd_data [2];

    assign rd_addr[0] = rna;
    assign rd_addr[1] = rnb;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        assign rd_data[gi] = (rd_addr[gi] == '0)                 ? '0     :
                             (WBwreg && (rd_addr[gi] == WBwn))   ? WBdata :
                                                                   regs_reg[rd_addr[gi]];
    end

    assign qa = rd_data[0];
    assign qb = rd_data[1];

    logic [31:0] retired_reg;

    // Count every valid slot leaving WB, writer or not; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_reg <= '0;
        end else if (wb_slot.valid) begin
            retired_reg <= retired_reg + 32'd1;
        end
    end

    assign WBretired = retired_reg;

endmodule

// File: tb/tb_pipe_wb.sv
// Directed bench for pipe_wb: a table of single-instruction vectors plus
// hand-written sequences for back-to-back writes, reset and counter wrap.
module tb_pipe_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEMvalid, MEMwreg, MEMm2reg;
    logic [4:0]  MEMwn;
    logic [31:0] MEMaluResult, MEMmemOut;
    logic        stall, flush;
    logic [4:0]  rna, rnb;
    logic [31:0] qa, qb;
    logic        WBwreg;
    logic [4:0]  WBwn;
    logic [31:0] WBdata;
    logic [31:0] WBretired;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_ret;

    pipe_wb dut (
        .clk          (clk),
        .rst          (rst),
        .MEMvalid     (MEMvalid),
        .MEMwreg      (MEMwreg),
        .MEMm2reg     (MEMm2reg),
        .MEMwn        (MEMwn),
        .MEMaluResult (MEMaluResult),
        .MEMmemOut    (MEMmemOut),
        .stall        (stall),
        .flush        (flush),
        .rna          (rna),
        .rnb          (rnb),
        .qa           (qa),
        .qb           (qb),
        .WBwreg       (WBwreg),
        .WBwn         (WBwn),
        .WBdata       (WBdata),
        .WBretired    (WBretired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid, wreg, m2reg, stall, flush;
        logic [4:0]  wn, rn;
        logic [31:0] alu, mem;
        logic        exp_wreg;
        logic [4:0]  exp_wn;
        logic [31:0] exp_data, exp_q_wb, exp_q_after;
        logic [31:0] delta;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        MEMvalid = 0; MEMwreg = 0; MEMm2reg = 0; MEMwn = '0;
        MEMaluResult = '0; MEMmemOut = '0; stall = 0; flush = 0;
    endtask

    task automatic drive(input logic v, input logic w, input logic m, input logic [4:0] wn,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic st, input logic fl);
        MEMvalid = v; MEMwreg = w; MEMm2reg = m; MEMwn = wn;
        MEMaluResult = alu; MEMmemOut = mem; stall = st; flush = fl;
    endtask

    initial begin
        // name, valid wreg m2reg stall flush, wn rn, alu mem,
        // exp_wreg exp_wn exp_data exp_q_wb exp_q_after delta
        vecs[0] = '{"alu_r5",     1,1,0,0,0,  5,5,  32'h1234, 32'h0,        1, 5, 32'h1234,     32'h1234,     32'h1234,     1};
        vecs[1] = '{"load_r7",    1,1,1,0,0,  7,7,  32'h40,   32'hDEADBEEF, 1, 7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1};
        vecs[2] = '{"write_r0",   1,1,0,0,0,  0,0,  32'hFFFF, 32'h0,        1, 0, 32'hFFFF,     32'h0,        32'h0,        1};
        vecs[3] = '{"flush_r5",   1,1,0,0,1,  5,5,  32'hAAAA, 32'h0,        0, 0, 32'h0,        32'h1234,     32'h1234,     0};
        vecs[4] = '{"stall_r5",   1,1,0,1,0,  5,5,  32'hAAAA, 32'h0,        0, 0, 32'h0,        32'h1234,     32'h1234,     0};
        vecs[5] = '{"stfl_r5",    1,1,0,1,1,  5,5,  32'hAAAA, 32'h0,        0, 0, 32'h0,        32'h1234,     32'h1234,     0};
        vecs[6] = '{"nowreg_r7",  1,0,0,0,0,  7,7,  32'h55,   32'h0,        0, 7, 32'h55,       32'hDEADBEEF, 32'hDEADBEEF, 1};
        vecs[7] = '{"invalid_r7", 0,1,0,0,0,  7,7,  32'h77,   32'h0,        0, 7, 32'h77,       32'hDEADBEEF, 32'hDEADBEEF, 0};

        idle();
        rna = '0; rnb = '0;
        rst = 1;
        step();
        step();
        rst = 0;

        // Reset state and an all-zero register file
        chk("reset_wbwreg",  {31'b0, WBwreg}, 32'h0);
        chk("reset_wbdata",  WBdata, 32'h0);
        chk("reset_wbwn",    {27'b0, WBwn}, 32'h0);
        chk("reset_retired", WBretired, 32'h0);
        for (int a = 0; a < 32; a++) begin
            rna = a[4:0]; rnb = 5'(31 - a);
            #1;
            chk($sformatf("reset_qa_r%0d", a), qa, 32'h0);
            chk($sformatf("reset_qb_r%0d", 31 - a), qb, 32'h0);
        end
        $display("[TB] reset state and register scan checked");
        exp_ret = 32'd0;

        // Table-driven single-instruction vectors
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].valid, vecs[i].wreg, vecs[i].m2reg, vecs[i].wn,
                  vecs[i].alu, vecs[i].mem, vecs[i].stall, vecs[i].flush);
            step();
            idle();
            rna = vecs[i].rn; rnb = vecs[i].rn;
            #1;
            chk({vecs[i].name, "_wbwreg"},  {31'b0, WBwreg}, {31'b0, vecs[i].exp_wreg});
            chk({vecs[i].name, "_wbwn"},    {27'b0, WBwn}, {27'b0, vecs[i].exp_wn});
            chk({vecs[i].name, "_wbdata"},  WBdata, vecs[i].exp_data);
            chk({vecs[i].name, "_qa_wb"},   qa, vecs[i].exp_q_wb);
            chk({vecs[i].name, "_qb_wb"},   qb, vecs[i].exp_q_wb);
            chk({vecs[i].name, "_ret_wb"},  WBretired, exp_ret);
            step();
            exp_ret = exp_ret + vecs[i].delta;
            chk({vecs[i].name, "_qa_after"}, qa, vecs[i].exp_q_after);
            chk({vecs[i].name, "_qb_after"}, qb, vecs[i].exp_q_after);
            chk({vecs[i].name, "_retired"},  WBretired, exp_ret);
            $display("[TB] vector %s: wbdata=0x%08h qa=0x%08h retired=%0d",
                     vecs[i].name, WBdata, qa, WBretired);
        end

        // Back-to-back writes to r9: later one wins in bypass and file
        rna = 5'd9; rnb = 5'd5;
        drive(1, 1, 0, 5'd9, 32'h111, 32'h0, 0, 0);
        step();
        drive(1, 1, 0, 5'd9, 32'h222, 32'h0, 0, 0);
        #1;
        chk("b2b_qa_first", qa, 32'h111);
        chk("b2b_qb_other", qb, 32'h1234);
        step();
        idle();
        #1;
        chk("b2b_qa_second", qa, 32'h222);
        step();
        chk("b2b_qa_stored", qa, 32'h222);
        exp_ret = exp_ret + 32'd2;
        chk("b2b_retired", WBretired, exp_ret);
        $display("[TB] back-to-back r9: qa=0x%08h retired=%0d", qa, WBretired);

        // Reset while a write to r3 occupies WB
        drive(1, 1, 0, 5'd3, 32'h333, 32'h0, 0, 0);
        step();
        idle();
        rst = 1;
        rna = 5'd3; rnb = 5'd5;
        #1;
        chk("rstmid_bypass_before", qa, 32'h333);
        step();
        rst = 0;
        #1;
        chk("rstmid_qa_r3",   qa, 32'h0);
        chk("rstmid_qb_r5",   qb, 32'h0);
        chk("rstmid_retired", WBretired, 32'h0);
        step();
        chk("rstmid_qa_r3_later", qa, 32'h0);
        $display("[TB] reset mid-operation: r3=0x%08h retired=%0d", qa, WBretired);

        // Counter wrap from 0xFFFFFFFF
        force dut.retired_reg = 32'hFFFFFFFF;
        #1;
        release dut.retired_reg;
        #1;
        chk("wrap_preload", WBretired, 32'hFFFFFFFF);
        drive(1, 0, 0, 5'd4, 32'h4, 32'h0, 0, 0);
        step();
        idle();
        chk("wrap_in_wb", WBretired, 32'hFFFFFFFF);
        step();
        chk("wrap_to_zero", WBretired, 32'h0);
        $display("[TB] counter wrap: retired=%0d", WBretired);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
